// File: rtl/fifo_uart_sender_pkg.sv
// sender_pkg: FSM encoding, frame constants and baud divider helper.
// Build option UART_CHECKSUM_EN adds the CSUM state.
package sender_pkg;
  localparam logic [15:0] FRAME_HEAD = 16'h7A00;
  localparam int FRAME_WORDS_DEF = 721;
  localparam int CLK_FREQ_DEF = 200000000;
  localparam int BAUD_DEF = 115200;

  function automatic int baud_div(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_LAT,
    S_TX_HI,
    S_TX_LO,
`ifdef UART_CHECKSUM_EN
    S_CSUM,
`endif
    S_FIN
  } state_t;
endpackage

// File: rtl/fifo_uart_sender_if.sv
// fifo_uart_sender_if: control, FIFO read side and UART line bundle.
// master drives start/FIFO data, slave is the sender.
interface fifo_uart_sender_if;
  logic        start_send;
  logic [15:0] fifo_q;
  logic        fifo_empty;
  logic        fifo_rdreq;
  logic        uart_txd;
  logic        busy;
  logic        done;
  logic        underrun;

  modport master (
    output start_send, fifo_q, fifo_empty,
    input  fifo_rdreq, uart_txd, busy, done, underrun
  );

  modport slave (
    input  start_send, fifo_q, fifo_empty,
    output fifo_rdreq, uart_txd, busy, done, underrun
  );
endinterface

// File: rtl/fifo_uart_sender_tx.sv
// uart_tx_byte: 8N1 byte shifter with baud counter.
// tx_done marks the last stop-bit cycle; a new start there runs back-to-back.
module uart_tx_byte #(
  parameter int BAUD_DIV = 8
) (
  input  logic       Clk,
  input  logic       Rst_n,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       txd
);
  localparam logic [10:0] BAUD_LAST = 11'(BAUD_DIV - 1);

  logic [10:0] r_baud;
  logic [3:0]  r_bit;
  logic [8:0]  r_shift;
  logic        r_busy;
  logic        r_txd;
  logic        w_bit_end;
  logic        w_load;

  assign w_bit_end = (r_baud == BAUD_LAST);
  assign tx_done   = r_busy && w_bit_end && (r_bit == 4'd9);
  assign w_load    = tx_start && (!r_busy || tx_done);
  assign tx_busy   = r_busy;
  assign txd       = r_txd;

  // Load a byte (start bit), then shift data and stop bit each BAUD_DIV cycles.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '1;
      r_busy  <= 1'b0;
      r_txd   <= 1'b1;
    end else if (w_load) begin
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= {1'b1, tx_data};
      r_busy  <= 1'b1;
      r_txd   <= 1'b0;
    end else if (r_busy) begin
      if (!w_bit_end) begin
        r_baud <= r_baud + 11'd1;
      end else begin
        r_baud <= '0;
        if (r_bit == 4'd9) begin
          r_busy <= 1'b0;
        end else begin
          r_txd   <= r_shift[0];
          r_shift <= {1'b1, r_shift[8:1]};
          r_bit   <= r_bit + 4'd1;
        end
      end
    end
  end
endmodule

// File: rtl/fifo_uart_sender.sv
// fifo_uart_sender: drains one frame from the FIFO, MSB byte first, over UART.
// Define UART_CHECKSUM_EN to append a modulo-256 checksum byte.
module fifo_uart_sender
  import sender_pkg::*;
#(
  parameter int CLK_FREQ    = CLK_FREQ_DEF,
  parameter int BAUD        = BAUD_DEF,
  parameter int BAUD_DIV    = baud_div(CLK_FREQ, BAUD),
  parameter int FRAME_WORDS = FRAME_WORDS_DEF
) (
  input logic               Clk,
  input logic               Rst_n,
  fifo_uart_sender_if.slave bus
);
  state_t      r_state;
  state_t      w_next;
  logic [15:0] r_word;
  logic [9:0]  r_cnt;
  logic        w_last;
  logic        w_tx_start;
  logic [7:0]  w_tx_data;
  logic        w_tx_busy;
  logic        w_tx_done;
`ifdef UART_CHECKSUM_EN
  logic [7:0]  r_sum;
`endif

  assign w_last   = (r_cnt == 10'(FRAME_WORDS));
  assign bus.busy = (r_state != S_IDLE) || w_tx_busy;

  uart_tx_byte #(.BAUD_DIV(BAUD_DIV)) u_tx (
    .Clk      (Clk),
    .Rst_n    (Rst_n),
    .tx_start (w_tx_start),
    .tx_data  (w_tx_data),
    .tx_busy  (w_tx_busy),
    .tx_done  (w_tx_done),
    .txd      (bus.uart_txd)
  );

  // State register.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Word latch and saturating word counter.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_word <= '0;
      r_cnt  <= '0;
    end else begin
      if (r_state == S_LAT) r_word <= bus.fifo_q;
      if (r_state == S_IDLE && bus.start_send) r_cnt <= '0;
      else if (bus.fifo_rdreq && !w_last) r_cnt <= r_cnt + 10'd1;
    end
  end

`ifdef UART_CHECKSUM_EN
  // Running sum of every frame byte handed to the shifter.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) r_sum <= '0;
    else if (r_state == S_IDLE && bus.start_send) r_sum <= '0;
    else if (w_tx_start && r_state != S_TX_LO) r_sum <= r_sum + w_tx_data;
  end
`endif

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (bus.start_send) w_next = S_RD;
      S_RD:    w_next = bus.fifo_empty ? S_FIN : S_LAT;
      S_LAT:   w_next = S_TX_HI;
      S_TX_HI: if (w_tx_done) w_next = S_TX_LO;
`ifdef UART_CHECKSUM_EN
      S_TX_LO: if (w_tx_done) w_next = w_last ? S_CSUM : S_RD;
      S_CSUM:  if (w_tx_done) w_next = S_FIN;
`else
      S_TX_LO: if (w_tx_done) w_next = w_last ? S_FIN : S_RD;
`endif
      S_FIN:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Outputs; the high byte is issued from LAT straight off fifo_q.
  always_comb begin
    bus.fifo_rdreq = 1'b0;
    bus.underrun   = 1'b0;
    bus.done       = 1'b0;
    w_tx_start     = 1'b0;
    w_tx_data      = r_word[15:8];
    unique case (r_state)
      S_RD: begin
        bus.fifo_rdreq = !bus.fifo_empty;
        bus.underrun   = bus.fifo_empty;
      end
      S_LAT: begin
        w_tx_start = 1'b1;
        w_tx_data  = bus.fifo_q[15:8];
      end
      S_TX_HI: begin
        w_tx_start = w_tx_done;
        w_tx_data  = r_word[7:0];
      end
`ifdef UART_CHECKSUM_EN
      S_TX_LO: begin
        w_tx_start = w_tx_done && w_last;
        w_tx_data  = r_sum;
      end
`endif
      S_FIN:   bus.done = 1'b1;
      default: ;
    endcase
  end
endmodule

// File: tb/tb_fifo_uart_sender.sv
// tb_fifo_uart_sender: table, random and long-frame checks of the sender.
// A behavioural FIFO, a UART line decoder and a byte-list model give expectations.
`timescale 1ns/1ps
module tb_fifo_uart_sender;
  import sender_pkg::*;

  localparam int DA = 8;
  localparam int FA = 2;
  localparam int DB = 2;
  localparam int FB = 721;

  logic Clk = 1'b0;
  logic Rst_n = 1'b0;
  always #5 Clk = ~Clk;

  fifo_uart_sender_if ifA ();
  fifo_uart_sender_if ifB ();

  fifo_uart_sender #(.BAUD_DIV(DA), .FRAME_WORDS(FA)) dutA (
    .Clk(Clk), .Rst_n(Rst_n), .bus(ifA)
  );
  fifo_uart_sender #(.BAUD_DIV(DB), .FRAME_WORDS(FB)) dutB (
    .Clk(Clk), .Rst_n(Rst_n), .bus(ifB)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  logic [15:0] memA [0:1023];
  logic [15:0] memB [0:1023];
  int wpA = 0, rpA = 0, wpB = 0, rpB = 0;
  logic clrA = 1'b0;

  assign ifA.fifo_empty = (rpA == wpA);
  assign ifB.fifo_empty = (rpB == wpB);

  always @(posedge Clk) begin
    if (clrA) rpA <= wpA;
    else if (ifA.fifo_rdreq && rpA != wpA) begin
      ifA.fifo_q <= memA[rpA];
      rpA <= rpA + 1;
    end
  end

  always @(posedge Clk) begin
    if (ifB.fifo_rdreq && rpB != wpB) begin
      ifB.fifo_q <= memB[rpB];
      rpB <= rpB + 1;
    end
  end

  int rdA = 0, doneA = 0, undA = 0, rdB = 0, doneB = 0, undB = 0;
  always @(negedge Clk) begin
    if (ifA.fifo_rdreq) rdA++;
    if (ifA.done) doneA++;
    if (ifA.underrun) undA++;
    if (ifB.fifo_rdreq) rdB++;
    if (ifB.done) doneB++;
    if (ifB.underrun) undB++;
  end

  logic [7:0] rxqA[$], rxqB[$];
  int rxsA[$], rxsB[$];
  int gl [2] = '{0, 0};
  bit rx_act [2] = '{0, 0};
  bit rx_gl [2];
  int rx_t [2];
  int rx_st [2];
  logic [9:0] rx_v [2];

  always @(negedge Clk) begin
    for (int i = 0; i < 2; i++) begin
      logic ln;
      int d;
      ln = (i == 0) ? ifA.uart_txd : ifB.uart_txd;
      d = (i == 0) ? DA : DB;
      if (!Rst_n) begin
        rx_act[i] = 1'b0;
      end else begin
        if (!rx_act[i] && !ln) begin
          rx_act[i] = 1'b1;
          rx_t[i] = 0;
          rx_gl[i] = 1'b0;
          rx_v[i] = '0;
          rx_st[i] = cyc;
        end
        if (rx_act[i]) begin
          if (rx_t[i] % d == 0) rx_v[i][rx_t[i] / d] = ln;
          else if (ln != rx_v[i][rx_t[i] / d]) rx_gl[i] = 1'b1;
          if (rx_t[i] == 10 * d - 1) begin
            rx_act[i] = 1'b0;
            if (!rx_v[i][9] || rx_gl[i]) gl[i]++;
            if (i == 0) begin
              rxqA.push_back(rx_v[i][8:1]);
              rxsA.push_back(rx_st[i]);
            end else begin
              rxqB.push_back(rx_v[i][8:1]);
              rxsB.push_back(rx_st[i]);
            end
          end else begin
            rx_t[i]++;
          end
        end
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic int gap_errs(input int s[$], input int base,
                                  input int nb, input int wbytes,
                                  input int d);
    int e = 0;
    for (int j = 1; j < nb; j++) begin
      int want;
      want = 10 * d + ((j < wbytes && j % 2 == 0) ? 2 : 0);
      if (s[base + j] - s[base + j - 1] != want) e++;
    end
    return e;
  endfunction

  task automatic pulse_a();
    ifA.start_send = 1'b1;
    @(posedge Clk); #1;
    ifA.start_send = 1'b0;
  endtask

  task automatic run_a(input string nm, input int n,
                       input logic [15:0] w0, input logic [15:0] w1,
                       input logic [15:0] w2, input bit rs,
                       input int erd, input int eund);
    logic [7:0] exp[$];
    logic [15:0] ws [3];
    logic [15:0] w;
    logic [7:0] s;
    int nrd, rb, db, ub, gb, qb, c0, nb;
    ws[0] = w0; ws[1] = w1; ws[2] = w2;
    for (int i = 0; i < n; i++) memA[wpA + i] = ws[i];
    wpA = wpA + n;
    nrd = (n < FA) ? n : FA;
    for (int i = 0; i < nrd; i++) begin
      w = ws[i];
      exp.push_back(w[15:8]);
      exp.push_back(w[7:0]);
    end
`ifdef UART_CHECKSUM_EN
    if (n >= FA) begin
      s = 8'h00;
      foreach (exp[k]) s = s + exp[k];
      exp.push_back(s);
    end
`endif
    repeat (2) @(posedge Clk); #1;
    rb = rdA; db = doneA; ub = undA; gb = gl[0]; qb = rxqA.size();
    c0 = cyc;
    pulse_a();
    chk({nm, " busy_hi"}, 32'(ifA.busy), 1);
    if (rs) begin
      repeat (100) @(posedge Clk); #1;
      pulse_a();
    end
    for (int k = 0; k < 3000 && doneA == db; k++) @(posedge Clk);
    repeat (4) @(posedge Clk); #1;
    nb = rxqA.size() - qb;
    chk({nm, " done"}, doneA - db, 1);
    chk({nm, " busy_lo"}, 32'(ifA.busy), 0);
    chk({nm, " rdreq"}, rdA - rb, erd);
    chk({nm, " underrun"}, undA - ub, eund);
    chk({nm, " nbytes"}, nb, exp.size());
    chk({nm, " bitshape"}, gl[0] - gb, 0);
    for (int j = 0; j < nb && j < exp.size(); j++)
      chk($sformatf("%s byte%0d", nm, j), 32'(rxqA[qb + j]), 32'(exp[j]));
    if (nb > 0) begin
      chk({nm, " latency"}, rxsA[qb] - c0, 3);
      chk({nm, " gaps"}, gap_errs(rxsA, qb, nb, 2 * nrd, DA), 0);
    end
    clrA = 1'b1;
    @(posedge Clk); #1;
    clrA = 1'b0;
  endtask

  typedef struct {
    int n;
    logic [15:0] w0;
    logic [15:0] w1;
    logic [15:0] w2;
    bit rs;
    int erd;
    int eund;
  } vec_t;

  vec_t vt [5];

  initial begin
    logic [7:0] expb[$];
    logic [7:0] s;
    logic [15:0] w;
    int rb, db, ub, gb, qb, nb, nbad, n;

    vt[0] = '{2, FRAME_HEAD, 16'h1234, 16'h0000, 1'b0, 2, 0};
    vt[1] = '{1, FRAME_HEAD, 16'h1234, 16'h0000, 1'b0, 1, 1};
    vt[2] = '{2, FRAME_HEAD, 16'h1234, 16'h0000, 1'b1, 2, 0};
    vt[3] = '{0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 0, 1};
    vt[4] = '{3, FRAME_HEAD, 16'hFFFF, 16'h5555, 1'b0, 2, 0};

    ifA.start_send = 1'b0;
    ifB.start_send = 1'b0;
    repeat (3) @(posedge Clk); #1;
    chk("rst txd", 32'(ifA.uart_txd), 1);
    chk("rst busy", 32'(ifA.busy), 0);
    chk("rst done", 32'(ifA.done), 0);
    chk("rst underrun", 32'(ifA.underrun), 0);
    chk("rst rdreq", 32'(ifA.fifo_rdreq), 0);
    Rst_n = 1'b1;
    repeat (2) @(posedge Clk); #1;

    for (int i = 0; i < 5; i++)
      run_a($sformatf("vec%0d", i), vt[i].n, vt[i].w0, vt[i].w1,
            vt[i].w2, vt[i].rs, vt[i].erd, vt[i].eund);

    for (int i = 0; i < 6; i++) begin
      n = $urandom_range(0, 3);
      run_a($sformatf("rnd%0d", i), n, 16'($urandom), 16'($urandom),
            16'($urandom), 1'b0, (n < FA) ? n : FA, (n < FA) ? 1 : 0);
    end

    memA[wpA] = FRAME_HEAD;
    memA[wpA + 1] = 16'hA55A;
    wpA = wpA + 2;
    repeat (2) @(posedge Clk); #1;
    pulse_a();
    repeat (30) @(posedge Clk); #2;
    chk("pre_rst txd", 32'(ifA.uart_txd), 0);
    Rst_n = 1'b0;
    #1;
    chk("mid_rst txd", 32'(ifA.uart_txd), 1);
    chk("mid_rst busy", 32'(ifA.busy), 0);
    repeat (2) @(posedge Clk); #1;
    Rst_n = 1'b1;
    clrA = 1'b1;
    @(posedge Clk); #1;
    clrA = 1'b0;
    run_a("post_rst", 2, FRAME_HEAD, 16'hBEEF, 16'h0000, 1'b0, 2, 0);

    memB[0] = FRAME_HEAD;
    for (int i = 0; i < FB - 1; i++) memB[i + 1] = 16'(i);
    wpB = FB;
    for (int i = 0; i < FB; i++) begin
      w = memB[i];
      expb.push_back(w[15:8]);
      expb.push_back(w[7:0]);
    end
`ifdef UART_CHECKSUM_EN
    s = 8'h00;
    foreach (expb[k]) s = s + expb[k];
    expb.push_back(s);
`endif
    repeat (2) @(posedge Clk); #1;
    rb = rdB; db = doneB; ub = undB; gb = gl[1]; qb = rxqB.size();
    ifB.start_send = 1'b1;
    @(posedge Clk); #1;
    ifB.start_send = 1'b0;
    for (int k = 0; k < 40000 && doneB == db; k++) @(posedge Clk);
    repeat (4) @(posedge Clk); #1;
    nb = rxqB.size() - qb;
    nbad = 0;
    for (int j = 0; j < nb && j < expb.size(); j++)
      if (rxqB[qb + j] != expb[j]) nbad++;
    chk("big done", doneB - db, 1);
    chk("big busy_lo", 32'(ifB.busy), 0);
    chk("big rdreq", rdB - rb, FB);
    chk("big underrun", undB - ub, 0);
    chk("big nbytes", nb, expb.size());
    chk("big bytes_wrong", nbad, 0);
    chk("big bitshape", gl[1] - gb, 0);
    chk("big gaps", gap_errs(rxsB, qb, nb, 2 * FB, DB), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
